motoro3_line_param_seq: RTL and testbench

Sequential, parametrised line-parameter engine for the N-phase motor driver. On a `start` strobe it latches the step command. For every phase it then computes:
- an interpolated sine level,
- a power-scaled PWM on-length, clamped and masked against the register limits,
- the per-sub-step speed count.

It publishes all results atomically with a one-cycle `done` pulse. A single shared multiplier is reused across phases. The block sits between the step sequencer and the per-phase PWM generators.

---
 rtl/motoro3_line_param_seq_if.sv | 33 +++
 rtl/motoro3_line_param_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_motoro3_line_param_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/motoro3_line_param_seq_if.sv
// Request/result bundle between the step sequencer and the line-parameter engine.
interface motoro3_line_param_seq_if #(
  parameter int PHASES  = 3,
  parameter int PWM_W   = 12,
  parameter int SPEED_W = 25
);
  logic                      start;
  logic [3:0]                lcStep;
  logic [1:0]                m3LpwmSplitStep;
  logic [1:0]                m3r_stepSplitMax;
  logic [7:0]                m3r_power_percent;
  logic [SPEED_W-1:0]        m3r_stepCNT_speedSET;
  logic [11:0]               m3r_pwmLenWant;
  logic [11:0]               m3r_pwmMinMask;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [PHASES*12-1:0]      slLen;
  logic [PHASES*PWM_W-1:0]   plLen;
  logic [SPEED_W-1:0]        subStepCnt;

  modport master (
    output start, lcStep, m3LpwmSplitStep, m3r_stepSplitMax, m3r_power_percent,
           m3r_stepCNT_speedSET, m3r_pwmLenWant, m3r_pwmMinMask,
    input  busy, done, err, slLen, plLen, subStepCnt
  );

  modport slave (
    input  start, lcStep, m3LpwmSplitStep, m3r_stepSplitMax, m3r_power_percent,
           m3r_stepCNT_speedSET, m3r_pwmLenWant, m3r_pwmMinMask,
    output busy, done, err, slLen, plLen, subStepCnt
  );
endinterface

// File: rtl/motoro3_line_param_seq.sv
// Per-phase sine interpolation, power scaling and PWM clamp/mask, one shared multiplier,
// results published atomically with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | validate latched step; invalid -> err pulse, back to IDLE
// INTERP | interpolate sine level for current phase into staging
// SCALE  | multiply level by power percent
// CLAMP  | cap at pwmLenWant, mask below pwmMinMask, store to staging
// DONE   | outputs just published, done high; behaves as idle for start
module motoro3_line_param_seq #(
  parameter int PHASES  = 3,
  parameter int PWM_W   = 12,
  parameter int SPEED_W = 25
) (
  input logic                     clk,
  input logic                     nRst,
  motoro3_line_param_seq_if.slave bus
);

  localparam int STRIDE = 12 / PHASES;
  localparam int PH_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_INTERP, ST_SCALE, ST_CLAMP, ST_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [3:0]                r_step;
  logic [1:0]                r_sp;
  logic [1:0]                r_ssm;
  logic [7:0]                r_pct;
  logic [SPEED_W-1:0]        r_speed;
  logic [11:0]               r_want;
  logic [11:0]               r_mask;
  logic [PH_W-1:0]           r_phase;
  logic [11:0]               r_interp;
  logic [13:0]               r_scaled;
  logic [PHASES*12-1:0]      r_sl_stage;
  logic [PHASES*PWM_W-1:0]   r_pl_stage;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_err;
  logic [PHASES*12-1:0]      r_sl;
  logic [PHASES*PWM_W-1:0]   r_pl;
  logic [SPEED_W-1:0]        r_sub;

  logic                      w_accept;
  logic                      w_load_out;
  logic                      w_fire_err;
  logic                      w_last;
  logic [1:0]                w_ssm_in;
  logic [1:0]                w_sp_lim;
  logic [4:0]                w_off;
  logic [4:0]                w_sum;
  logic [3:0]                w_s;
  logic [3:0]                w_n;
  logic [11:0]               w_s_val;
  logic [11:0]               w_n_val;
  logic signed [13:0]        w_diff;
  logic signed [13:0]        w_scaled_diff;
  logic signed [13:0]        w_shift;
  logic signed [13:0]        w_interp_s;
  logic [11:0]               w_interp;
  logic [29:0]               w_prod;
  logic [11:0]               w_capped;
  logic [11:0]               w_pl_val;
  logic [PHASES*12-1:0]      w_sl_stage_nxt;
  logic [PHASES*PWM_W-1:0]   w_pl_stage_nxt;

  function automatic logic [11:0] sine_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    sine_lut = 12'd2048;
      4'd1:    sine_lut = 12'd3071;
      4'd2:    sine_lut = 12'd3821;
      4'd3:    sine_lut = 12'd4095;
      4'd4:    sine_lut = 12'd3821;
      4'd5:    sine_lut = 12'd3071;
      4'd6:    sine_lut = 12'd2048;
      4'd7:    sine_lut = 12'd1024;
      4'd8:    sine_lut = 12'd274;
      4'd9:    sine_lut = 12'd0;
      4'd10:   sine_lut = 12'd274;
      4'd11:   sine_lut = 12'd1024;
      default: sine_lut = 12'd0;
    endcase
  endfunction

  assign w_last   = (r_phase == PH_W'(PHASES - 1));
  assign w_ssm_in = (bus.m3r_stepSplitMax == 2'd3) ? 2'd2 : bus.m3r_stepSplitMax;
  assign w_sp_lim = (w_ssm_in == 2'd0) ? 2'd0 : (w_ssm_in == 2'd1) ? 2'd1 : 2'd3;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_out  = 1'b0;
    w_fire_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_CHECK;
          w_accept    = 1'b1;
        end
      end
      ST_CHECK: begin
        if (r_step >= 4'd12) begin
          w_state_nxt = ST_IDLE;
          w_fire_err  = 1'b1;
        end else begin
          w_state_nxt = ST_INTERP;
        end
      end
      ST_INTERP: w_state_nxt = ST_SCALE;
      ST_SCALE:  w_state_nxt = ST_CLAMP;
      ST_CLAMP: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
          w_load_out  = 1'b1;
        end else begin
          w_state_nxt = ST_INTERP;
        end
      end
      // busy is already low here, so a new request may start immediately
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_CHECK;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_off = 5'(int'(r_phase) * STRIDE);
    w_sum = {1'b0, r_step} + w_off;
    w_s   = (w_sum >= 5'd12) ? 4'(w_sum - 5'd12) : 4'(w_sum);
    w_n   = (w_s == 4'd11) ? 4'd0 : w_s + 4'd1;
  end

  assign w_s_val       = sine_lut(w_s);
  assign w_n_val       = sine_lut(w_n);
  assign w_diff        = $signed({2'b00, w_n_val}) - $signed({2'b00, w_s_val});
  assign w_scaled_diff = w_diff * $signed({12'd0, r_sp});
  assign w_shift       = w_scaled_diff >>> r_ssm;
  assign w_interp_s    = $signed({2'b00, w_s_val}) + w_shift;
  assign w_interp      = 12'(w_interp_s);

  assign w_prod   = 30'(r_interp) * 30'(r_pct) * 30'(10'd655);
  assign w_capped = (r_scaled > {2'b00, r_want}) ? r_want : 12'(r_scaled);
  assign w_pl_val = (w_capped < r_mask) ? 12'd0 : w_capped;

  always_comb begin
    w_sl_stage_nxt = r_sl_stage;
    w_pl_stage_nxt = r_pl_stage;
    for (int k = 0; k < PHASES; k++) begin
      if (r_phase == PH_W'(k)) begin
        w_sl_stage_nxt[k*12 +: 12]       = w_interp;
        w_pl_stage_nxt[k*PWM_W +: PWM_W] = PWM_W'(w_pl_val);
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_step     <= '0;
      r_sp       <= '0;
      r_ssm      <= '0;
      r_pct      <= '0;
      r_speed    <= '0;
      r_want     <= '0;
      r_mask     <= '0;
      r_phase    <= '0;
      r_interp   <= '0;
      r_scaled   <= '0;
      r_sl_stage <= '0;
      r_pl_stage <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sl       <= '0;
      r_pl       <= '0;
      r_sub      <= '0;
    end else begin
      r_done <= w_load_out;
      r_err  <= w_fire_err;
      if (w_accept) begin
        r_step  <= bus.lcStep;
        r_ssm   <= w_ssm_in;
        r_sp    <= (bus.m3LpwmSplitStep > w_sp_lim) ? w_sp_lim : bus.m3LpwmSplitStep;
        r_pct   <= bus.m3r_power_percent;
        r_speed <= bus.m3r_stepCNT_speedSET;
        r_want  <= bus.m3r_pwmLenWant;
        r_mask  <= bus.m3r_pwmMinMask;
        r_phase <= '0;
        r_busy  <= 1'b1;
      end else if (w_load_out || w_fire_err) begin
        r_busy <= 1'b0;
      end
      if (r_state == ST_INTERP) begin
        r_interp   <= w_interp;
        r_sl_stage <= w_sl_stage_nxt;
      end
      if (r_state == ST_SCALE) r_scaled <= 14'(w_prod >> 16);
      if (r_state == ST_CLAMP) begin
        r_pl_stage <= w_pl_stage_nxt;
        if (!w_last) r_phase <= r_phase + 1'b1;
      end
      // last phase goes straight from the clamp result so done and data coincide
      if (w_load_out) begin
        r_sl  <= r_sl_stage;
        r_pl  <= w_pl_stage_nxt;
        r_sub <= r_speed >> r_ssm;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.slLen      = r_sl;
  assign bus.plLen      = r_pl;
  assign bus.subStepCnt = r_sub;

endmodule

// File: tb/tb_motoro3_line_param_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors check them on done/err.
module tb_motoro3_line_param_seq;

  logic clk = 1'b0;
  logic nRst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  motoro3_line_param_seq_if #(.PHASES(3), .PWM_W(12), .SPEED_W(25)) bus3();
  motoro3_line_param_seq_if #(.PHASES(6), .PWM_W(12), .SPEED_W(25)) bus6();

  motoro3_line_param_seq #(.PHASES(3), .PWM_W(12), .SPEED_W(25)) dut3 (
    .clk(clk), .nRst(nRst), .bus(bus3.slave));
  motoro3_line_param_seq #(.PHASES(6), .PWM_W(12), .SPEED_W(25)) dut6 (
    .clk(clk), .nRst(nRst), .bus(bus6.slave));

  typedef struct {
    bit          is_err;
    logic [35:0] sl;
    logic [35:0] pl;
    logic [24:0] sub;
    int          t0;
  } exp3_t;

  typedef struct {
    logic [71:0] sl;
    logic [71:0] pl;
    logic [24:0] sub;
    int          t0;
  } exp6_t;

  exp3_t q3[$];
  exp6_t q6[$];
  logic [35:0] prev_sl = '0;
  logic [35:0] prev_pl = '0;
  logic [24:0] prev_sub = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // done is visible in the sample after the 10th edge following acceptance (cycle t+11)
  always @(negedge clk) begin
    exp3_t e;
    if (bus3.done || bus3.err) begin
      if (q3.size() == 0) begin
        flag("p3_unexpected_done_or_err");
      end else begin
        e = q3.pop_front();
        check("p3_kind_err", 64'(bus3.err), 64'(e.is_err));
        check("p3_kind_done", 64'(bus3.done), 64'(!e.is_err));
        check("p3_latency", 64'(cyc - e.t0), e.is_err ? 64'd1 : 64'd10);
        check("p3_busy_low", 64'(bus3.busy), 64'd0);
        check("p3_slLen", 64'(bus3.slLen), 64'(e.sl));
        check("p3_plLen", 64'(bus3.plLen), 64'(e.pl));
        check("p3_subStepCnt", 64'(bus3.subStepCnt), 64'(e.sub));
      end
    end
  end

  always @(negedge clk) begin
    exp6_t e;
    if (bus6.done || bus6.err) begin
      if (q6.size() == 0) begin
        flag("p6_unexpected_done_or_err");
      end else begin
        e = q6.pop_front();
        check("p6_err_low", 64'(bus6.err), 64'd0);
        check("p6_latency", 64'(cyc - e.t0), 64'd19);
        for (int k = 0; k < 6; k++) begin
          check($sformatf("p6_slLen_ph%0d", k), 64'(bus6.slLen[k*12 +: 12]), 64'(e.sl[k*12 +: 12]));
          check($sformatf("p6_plLen_ph%0d", k), 64'(bus6.plLen[k*12 +: 12]), 64'(e.pl[k*12 +: 12]));
        end
        check("p6_subStepCnt", 64'(bus6.subStepCnt), 64'(e.sub));
      end
    end
  end

  task automatic drive3(input logic [3:0] step, input logic [1:0] sp, input logic [1:0] smax,
                        input logic [7:0] pct, input logic [24:0] spd,
                        input logic [11:0] want, input logic [11:0] mask);
    bus3.lcStep               = step;
    bus3.m3LpwmSplitStep      = sp;
    bus3.m3r_stepSplitMax     = smax;
    bus3.m3r_power_percent    = pct;
    bus3.m3r_stepCNT_speedSET = spd;
    bus3.m3r_pwmLenWant       = want;
    bus3.m3r_pwmMinMask       = mask;
    bus3.start                = 1'b1;
  endtask

  // call right after a negedge; the following posedge is the accepting edge
  task automatic push3(input bit is_err, input logic [35:0] sl, input logic [35:0] pl,
                       input logic [24:0] sub);
    exp3_t e;
    e.is_err = is_err;
    e.t0     = cyc + 1;
    if (is_err) begin
      e.sl = prev_sl; e.pl = prev_pl; e.sub = prev_sub;
    end else begin
      e.sl = sl; e.pl = pl; e.sub = sub;
      prev_sl = sl; prev_pl = pl; prev_sub = sub;
    end
    q3.push_back(e);
  endtask

  task automatic release_start();
    @(negedge clk);
    bus3.start = 1'b0;
    check("p3_busy_after_accept", 64'(bus3.busy), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q3.size() != 0 || q6.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q3.size() != 0 || q6.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=drained", name);
      q3.delete();
      q6.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run3(input logic [3:0] step, input logic [1:0] sp, input logic [1:0] smax,
                      input logic [7:0] pct, input logic [24:0] spd,
                      input logic [11:0] want, input logic [11:0] mask,
                      input bit is_err, input logic [35:0] sl, input logic [35:0] pl,
                      input logic [24:0] sub, input string name);
    push3(is_err, sl, pl, sub);
    drive3(step, sp, smax, pct, spd, want, mask);
    release_start();
    wait_drain(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp6_t e6;
    int    n;
    nRst = 1'b0;
    bus3.start = 1'b0; bus3.lcStep = '0; bus3.m3LpwmSplitStep = '0; bus3.m3r_stepSplitMax = '0;
    bus3.m3r_power_percent = '0; bus3.m3r_stepCNT_speedSET = '0;
    bus3.m3r_pwmLenWant = '0; bus3.m3r_pwmMinMask = '0;
    bus6.start = 1'b0; bus6.lcStep = '0; bus6.m3LpwmSplitStep = '0; bus6.m3r_stepSplitMax = '0;
    bus6.m3r_power_percent = '0; bus6.m3r_stepCNT_speedSET = '0;
    bus6.m3r_pwmLenWant = '0; bus6.m3r_pwmMinMask = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus3.busy), 64'd0);
    check("reset_done", 64'(bus3.done), 64'd0);
    check("reset_err", 64'(bus3.err), 64'd0);
    check("reset_slLen", 64'(bus3.slLen), 64'd0);
    check("reset_plLen", 64'(bus3.plLen), 64'd0);
    check("reset_subStepCnt", 64'(bus3.subStepCnt), 64'd0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // nominal: phases at steps 0, 4, 8
    run3(4'd0, 2'd0, 2'd0, 8'd100, 25'd1000, 12'd4095, 12'd0, 1'b0,
         {12'd274, 12'd3821, 12'd2048}, {12'd273, 12'd3818, 12'd2046}, 25'd1000, "nominal");
    // half-step interpolation, both rising and falling segments
    run3(4'd2, 2'd1, 2'd1, 8'd100, 25'd1000, 12'd4095, 12'd0, 1'b0,
         {12'd649, 12'd1536, 12'd3958}, {12'd648, 12'd1535, 12'd3955}, 25'd500, "interp_half");
    // sp=3 with one split bit clips to sp=1
    run3(4'd2, 2'd3, 2'd1, 8'd100, 25'd2000, 12'd4095, 12'd0, 1'b0,
         {12'd649, 12'd1536, 12'd3958}, {12'd648, 12'd1535, 12'd3955}, 25'd1000, "sp_clip");

    // back-to-back: wrap 11->0, then clamp test accepted on the done cycle
    push3(1'b0, {12'd649, 12'd3958, 12'd1536}, {12'd648, 12'd3955, 12'd1535}, 25'd250);
    drive3(4'd11, 2'd2, 2'd2, 8'd100, 25'd1000, 12'd4095, 12'd0);
    release_start();
    n = 0;
    while (!bus3.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    push3(1'b0, {12'd1024, 12'd1024, 12'd4095}, {12'd2609, 12'd2609, 12'd3000}, 25'd1000);
    drive3(4'd3, 2'd0, 2'd0, 8'd255, 25'd1000, 12'd3000, 12'd0);
    release_start();
    wait_drain("back_to_back");

    run3(4'd8, 2'd0, 2'd0, 8'd100, 25'd1000, 12'd4095, 12'd300, 1'b0,
         {12'd3821, 12'd2048, 12'd274}, {12'd3818, 12'd2046, 12'd0}, 25'd1000, "min_mask");
    // split max 3 treated as 2, sp=3 kept, negative deltas floor under >>>
    run3(4'd0, 2'd3, 2'd3, 8'd100, 25'd1000, 12'd4095, 12'd0, 1'b0,
         {12'd68, 12'd3258, 12'd2815}, {12'd67, 12'd3256, 12'd2813}, 25'd250, "split_max3");

    run3(4'd12, 2'd0, 2'd0, 8'd100, 25'd777, 12'd4095, 12'd0, 1'b1, '0, '0, '0, "err_12");
    run3(4'd15, 2'd1, 2'd1, 8'd50, 25'd777, 12'd100, 12'd0, 1'b1, '0, '0, '0, "err_15");
    check("hold_slLen", 64'(bus3.slLen), 64'(prev_sl));
    check("hold_plLen", 64'(bus3.plLen), 64'(prev_pl));

    // start while busy must be ignored
    push3(1'b0, {12'd274, 12'd3821, 12'd2048}, {12'd273, 12'd3818, 12'd2046}, 25'd1000);
    drive3(4'd0, 2'd0, 2'd0, 8'd100, 25'd1000, 12'd4095, 12'd0);
    release_start();
    repeat (2) @(negedge clk);
    drive3(4'd5, 2'd1, 2'd1, 8'd50, 25'd64, 12'd10, 12'd5);
    @(negedge clk);
    bus3.start = 1'b0;
    wait_drain("ignored_start");
    repeat (20) @(negedge clk);

    // reset mid-run: no done, everything cleared
    drive3(4'd2, 2'd1, 2'd1, 8'd100, 25'd1000, 12'd4095, 12'd0);
    @(negedge clk);
    bus3.start = 1'b0;
    repeat (4) @(negedge clk);
    nRst = 1'b0;
    #1;
    check("midrst_busy", 64'(bus3.busy), 64'd0);
    check("midrst_slLen", 64'(bus3.slLen), 64'd0);
    check("midrst_plLen", 64'(bus3.plLen), 64'd0);
    check("midrst_subStepCnt", 64'(bus3.subStepCnt), 64'd0);
    @(negedge clk);
    nRst = 1'b1;
    prev_sl = '0; prev_pl = '0; prev_sub = '0;
    repeat (20) @(negedge clk);
    check("midrst_no_done_slLen", 64'(bus3.slLen), 64'd0);

    run3(4'd0, 2'd0, 2'd0, 8'd100, 25'd1000, 12'd4095, 12'd0, 1'b0,
         {12'd274, 12'd3821, 12'd2048}, {12'd273, 12'd3818, 12'd2046}, 25'd1000, "after_reset");

    // six phases: steps 0,2,4,6,8,10
    e6.sl  = {12'd274, 12'd274, 12'd2048, 12'd3821, 12'd3821, 12'd2048};
    e6.pl  = {12'd273, 12'd273, 12'd2046, 12'd3818, 12'd3818, 12'd2046};
    e6.sub = 25'd1000;
    e6.t0  = cyc + 1;
    q6.push_back(e6);
    bus6.lcStep = 4'd0; bus6.m3LpwmSplitStep = 2'd0; bus6.m3r_stepSplitMax = 2'd0;
    bus6.m3r_power_percent = 8'd100; bus6.m3r_stepCNT_speedSET = 25'd1000;
    bus6.m3r_pwmLenWant = 12'd4095; bus6.m3r_pwmMinMask = 12'd0;
    bus6.start = 1'b1;
    @(negedge clk);
    bus6.start = 1'b0;
    check("p6_busy_after_accept", 64'(bus6.busy), 64'd1);
    wait_drain("phases6");

    repeat (5) @(negedge clk);
    check("p3_queue_empty", 64'(q3.size()), 64'd0);
    check("p6_queue_empty", 64'(q6.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
